// File: rtl/l0_bank.sv
// Multi-row input buffer: `row` lockstep-written FIFOs with parallel or staggered (systolic skew) reads.
// Optional drop/refuse status counter enabled by defining L0_BANK_STATUS_EN.

module l0_row #(
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [bw-1:0] din,
    input  logic          wr_en,
    input  logic          pop_req,
    output logic [bw-1:0] dout,
    output logic          dvalid,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [bw-1:0] mem [depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          fire;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    // an empty row refuses the pop even if a write lands on the same edge
    assign fire  = pop_req & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
            dvalid <= 1'b0;
        end else begin
            dvalid <= fire;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (fire) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            case ({wr_en, fire})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module l0_bank #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [row*bw-1:0] in,
    input  logic              wr,
    input  logic              rd,
    input  logic              mode,
    output logic [row*bw-1:0] out,
    output logic [row-1:0]    out_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_empty
`ifdef L0_BANK_STATUS_EN
   ,output logic [15:0]       o_drop_cnt
`endif
);
    logic [row-1:0][bw-1:0] din_a, dout_a;
    logic [row-1:0]         stag, pop_req, full_r, empty_r;
    logic                   wr_en;

    assign din_a   = in;
    assign out     = dout_a;
    // full from registered occupancy only: a same-edge pop never admits a write
    assign wr_en   = wr & ~o_full;
    assign o_full  = |full_r;
    assign o_ready = ~o_full;
    assign o_empty = &empty_r;

    for (genvar i = 0; i < row; i++) begin : g_row
        if (i == 0) begin : g_head
            assign stag[i] = rd & mode;
        end else begin : g_tap
            logic sq;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) sq <= 1'b0;
                else        sq <= stag[i-1];
            end
            assign stag[i] = sq;
        end

        assign pop_req[i] = (rd & ~mode) | stag[i];

        l0_row #(.bw(bw), .depth(depth)) u_row (
            .clk     (clk),
            .reset   (reset),
            .din     (din_a[i]),
            .wr_en   (wr_en),
            .pop_req (pop_req[i]),
            .dout    (dout_a[i]),
            .dvalid  (out_valid[i]),
            .full    (full_r[i]),
            .empty   (empty_r[i])
        );
    end

`ifdef L0_BANK_STATUS_EN
    logic drop;
    assign drop = (wr & o_full) | |(pop_req & empty_r);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          o_drop_cnt <= '0;
        else if (drop && o_drop_cnt != '1)   o_drop_cnt <= o_drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_l0_bank.sv
// Directed self-checking bench for l0_bank at row=8, bw=4, depth=64.

module tb_l0_bank;
    logic        clk, reset, wr, rd, mode;
    logic [31:0] in, out;
    logic [7:0]  out_valid;
    logic        o_full, o_ready, o_empty;
`ifdef L0_BANK_STATUS_EN
    logic [15:0] o_drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] a, b, c, w;

    l0_bank #(.row(8), .bw(4), .depth(64)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .mode(mode),
        .out(out), .out_valid(out_valid), .o_full(o_full), .o_ready(o_ready),
        .o_empty(o_empty)
`ifdef L0_BANK_STATUS_EN
       ,.o_drop_cnt(o_drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_drop(input string tag, input logic [15:0] exp);
`ifdef L0_BANK_STATUS_EN
        chk(tag, {16'd0, o_drop_cnt}, {16'd0, exp});
`else
        chk(tag, {31'd0, o_ready}, {31'd0, ~o_full});
`endif
    endtask

    initial begin
        reset = 1'b0; wr = 1'b0; rd = 1'b0; mode = 1'b0; in = '0;
        #1;
        chk("rst_out", out, 32'h0);
        chk("rst_vld", {24'd0, out_valid}, 32'h0);
        chk("rst_full", {31'd0, o_full}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_empty", {31'd0, o_empty}, 32'd1);
        chk_drop("rst_drop", 16'd0);
        tick(); tick();
        reset = 1'b1;

        // parallel write/read of three words
        wr = 1'b1; in = 32'h01234567; tick();
        chk("wr_not_empty", {31'd0, o_empty}, 32'd0);
        in = 32'h89ABCDEF; tick();
        in = 32'h11111111; tick();
        wr = 1'b0; rd = 1'b1; mode = 1'b0;
        tick(); chk("par_out0", out, 32'h01234567); chk("par_vld0", {24'd0, out_valid}, 32'hFF);
        tick(); chk("par_out1", out, 32'h89ABCDEF); chk("par_vld1", {24'd0, out_valid}, 32'hFF);
        tick(); chk("par_out2", out, 32'h11111111); chk("par_vld2", {24'd0, out_valid}, 32'hFF);
        rd = 1'b0;
        chk("par_empty", {31'd0, o_empty}, 32'd1);
        tick();
        chk("par_idle_vld", {24'd0, out_valid}, 32'h0);
        chk("par_idle_hold", out, 32'h11111111);

        // single staggered read walks out_valid across the rows
        w = 32'h76543210;
        wr = 1'b1; in = w; tick();
        wr = 1'b0; rd = 1'b1; mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            rd = 1'b0;
            chk("stag_vld", {24'd0, out_valid}, 32'd1 << i);
            chk("stag_slice", {28'd0, out[4*i +: 4]}, {28'd0, w[4*i +: 4]});
        end
        mode = 1'b0;
        chk("stag_empty", {31'd0, o_empty}, 32'd1);

        // fill to depth across pointer wrap, overflow, drain
        wr = 1'b1;
        for (int k = 0; k < 64; k++) begin
            in = {16'(k), 16'(k)};
            tick();
        end
        chk("fill_full", {31'd0, o_full}, 32'd1);
        chk("fill_ready", {31'd0, o_ready}, 32'd0);
        in = 32'hDEADBEEF; tick();
        wr = 1'b0;
        chk("ovf_full", {31'd0, o_full}, 32'd1);
        chk_drop("ovf_drop", 16'd1);
        rd = 1'b1; mode = 1'b0;
        for (int k = 0; k < 64; k++) begin
            tick();
            chk("drain_out", out, {16'(k), 16'(k)});
            chk("drain_vld", {24'd0, out_valid}, 32'hFF);
        end
        rd = 1'b0;
        chk("drain_empty", {31'd0, o_empty}, 32'd1);
        chk("drain_ready", {31'd0, o_ready}, 32'd1);

        // read on an empty bank
        rd = 1'b1; tick(); rd = 1'b0;
        chk("emp_vld", {24'd0, out_valid}, 32'h0);
        chk("emp_hold", out, {16'd63, 16'd63});
        chk("emp_empty", {31'd0, o_empty}, 32'd1);
        chk_drop("emp_drop", 16'd2);
        wr = 1'b1; in = 32'hCAFEF00D; tick();
        wr = 1'b0; rd = 1'b1; tick(); rd = 1'b0;
        chk("emp_ptr_out", out, 32'hCAFEF00D);
        chk("emp_ptr_vld", {24'd0, out_valid}, 32'hFF);

        // staggered read overlapped by a parallel read on the next cycle
        a = 32'h87654321; b = 32'h1F2E3D4C;
        wr = 1'b1; in = a; tick();
        in = b; tick();
        wr = 1'b0; rd = 1'b1; mode = 1'b1; tick();
        chk("ovl_vld0", {24'd0, out_valid}, 32'h01);
        chk("ovl_row0", {28'd0, out[3:0]}, {28'd0, a[3:0]});
        mode = 1'b0; tick();
        rd = 1'b0;
        chk("ovl_vld1", {24'd0, out_valid}, 32'hFF);
        chk("ovl_out1", out, {a[31:4], b[3:0]});
        for (int i = 2; i < 8; i++) begin
            tick();
            chk("ovl_tail_vld", {24'd0, out_valid}, 32'd1 << i);
            chk("ovl_tail_slice", {28'd0, out[4*i +: 4]}, {28'd0, b[4*i +: 4]});
        end
        chk("ovl_row1_left", {31'd0, o_empty}, 32'd0);
        rd = 1'b1; tick(); rd = 1'b0;
        chk("ovl_last_vld", {24'd0, out_valid}, 32'h02);
        chk("ovl_last_row1", {28'd0, out[7:4]}, {28'd0, b[7:4]});
        chk("ovl_empty", {31'd0, o_empty}, 32'd1);
        chk_drop("ovl_drop", 16'd3);

        // reset in the middle of a staggered read
        c = 32'h9ABCDEF0;
        wr = 1'b1; in = c; tick();
        wr = 1'b0; rd = 1'b1; mode = 1'b1; tick();
        rd = 1'b0; mode = 1'b0;
        tick(); tick(); tick();
        chk("mid_vld3", {24'd0, out_valid}, 32'h08);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out", out, 32'h0);
        chk("mid_rst_vld", {24'd0, out_valid}, 32'h0);
        chk("mid_rst_empty", {31'd0, o_empty}, 32'd1);
        chk("mid_rst_full", {31'd0, o_full}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        chk_drop("mid_rst_drop", 16'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_vld", {24'd0, out_valid}, 32'h0);
        end
        chk("post_rst_empty", {31'd0, o_empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l0_bank.md
# l0_bank

Parametrised multi-row input buffer: `row` independent FIFOs of `depth` entries, each `bw` bits wide, filled in parallel from one packed bus. This block supersedes the fixed-width L0/IFIFO buffers feeding the MAC array in the corelet. It adds a runtime-selectable staggered (diagonal) read mode that produces the systolic input skew internally, and adds full/empty/occupancy-safe per-row pop logic.

## Interface
- `row`, 8, number of channels (FIFOs); ≥1
- `bw`, 4, bits per channel entry
- `depth`, 64, entries per FIFO; power of two, ≥2
- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: asynchronous, active-low; clears all state
- `in` input row*bw: write data; channel i = `in[bw*(i+1)-1:bw*i]`
- `wr` input 1: push `in` into all rows this cycle
- `rd` input 1: read request (parallel or staggered per `mode`)
- `mode` input 1: 0 = parallel read, 1 = staggered read; sampled on each `rd` cycle
- `out` output row*bw: registered read data, channel packing as `in`
- `out_valid` output row: bit i high one cycle after row i popped
- `o_full` output 1: any row holds `depth` entries
- `o_ready` output 1: `~o_full`
- `o_empty` output 1: all rows hold 0 entries
- `o_drop_cnt` output 16: only with `L0_BANK_STATUS_EN` (see Configuration)

## Operation
- Per row: storage array, write pointer, read pointer (log2(depth) bits, natural wrap), occupancy counter (log2(depth)+1 bits).
- Write: if `wr && !o_full`, all rows store `in` slice at their write pointer, pointers and counts +1. If `wr && o_full`: whole write dropped, no row changes (rows never diverge on writes).
- Full is evaluated from the registered occupancy only; a same-cycle pop does not admit a write when full.
- Pop request vector `pop_req[i] = (rd & ~mode) | stag[i]`.
- Stagger pipeline: `stag[0] = rd & mode` (combinational), `stag[i] = stag_q[i-1]`, where `stag_q` is a row-1 bit shift register that shifts every cycle regardless of `mode`. A staggered `rd` at cycle t pops row i at cycle t+i.
- Pending staggered pops still issue after `mode` switches to 0. If they coincide with a parallel pop of the same row, the row pops once (the request is OR'd, not counted twice).
- Row i pops iff `pop_req[i]` and its occupancy > 0. Popping an empty row is ignored: no pointer change, `out` slice holds, `out_valid[i]` = 0.
- On a pop: the `out` slice is loaded from the read-pointer entry, the read pointer is incremented, and `out_valid[i]` is set for exactly one cycle. Otherwise the `out` slice holds its last value.
- Simultaneous write and pop on a row: the count is unchanged. If the row was empty before the edge, the pop is refused and the write succeeds.

## Timing
- Reset (async assert): all pointers, counts, `stag_q` = 0. `out` = 0, `out_valid` = 0, `o_full` = 0, `o_ready` = 1, `o_empty` = 1, `o_drop_cnt` = 0. Release is synchronous-deasserted by the parent.
- Write at edge k makes the data poppable by `rd` at edge k+1 (minimum write-to-out latency 2 edges).
- Parallel `rd` at edge k: `out`/`out_valid` for all non-empty rows valid after edge k.
- Staggered `rd` at edge k: row i output valid after edge k+i. The full skew spans `row` cycles; back-to-back staggered `rd` streams one vector per cycle.
- Reset mid-stream discards the pending stagger pops and all stored data.
- Status outputs are registered-derived; they update the cycle after the causing edge.

## Configuration
- `L0_BANK_STATUS_EN` defined: adds port `o_drop_cnt`, a 16-bit saturating counter. It increments by 1 per cycle in which a write was dropped (full) or any row refused a pop (empty); if both occur in the same cycle it increments by 1. It holds at 16'hFFFF and clears on reset.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, then 3 parallel writes 0x01234567/0x89ABCDEF/0x11111111 (row=8, bw=4), 3 parallel `rd` -> `out` returns the same words in order, `out_valid`=8'hFF each cycle, then `o_empty`=1.
- Write 1 word, single staggered `rd` at cycle t -> `out_valid` = 8'h01,02,04,…,80 on cycles t..t+7; each row's slice matches the written nibble.
- Write `depth`=64 words -> `o_full`=1, `o_ready`=0; 65th write dropped. Then 64 pops -> values 0..63 in order (no wrap corruption) and `o_empty`=1.
- `rd` on empty bank -> `out` holds, `out_valid`=0, pointers unchanged. With `L0_BANK_STATUS_EN`, `o_drop_cnt` increments by 1.
- Staggered `rd`, switch `mode`=0 next cycle with parallel `rd` -> rows receiving both requests pop once; the total popped per row equals the requests' OR.
- Assert `reset` low during a staggered read at row 3 -> all outputs return to reset values immediately, no further `out_valid` pulses.
